mem_ctrl: RTL
=============

Name: mem_ctrl

Overview:
- Synchronous initiator that drives the 8-word x 8-bit gate-level word memory array (`mem`).
- Accepts read/write requests on a valid/ready handshake and sequences the memory's RW, address and data inputs with setup, strobe and hold phases.
- For reads, selects the addressed word from the array's eight word outputs, registers it and returns it on a valid/ready response channel.
- Sits between the test/CPU side and the memory array.

Parameters:
- ADDR_W, 3, address width; WORDS = 2**ADDR_W.
- DATA_W, 8, word width.
- WR_CYCLES, 1, cycles RW is held at write (0) during a write strobe; legal range 1..15.
- RD_LAT, 1, wait cycles after read address setup before capture; legal range 0..15.

Ports:
- clk  in  1  single clock; everything samples on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_wr  in  1  1 = write, 0 = read.
- req_adr  in  ADDR_W  word address.
- req_data  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_wr  out  1  echo of the request type.
- rsp_data  out  DATA_W  read data; 0 for writes.
- mem_rw  out  1  memory RW: 1 = read/hold, 0 = write.
- mem_adr  out  ADDR_W  memory address; bit 0 drives adr0.
- mem_din  out  DATA_W  memory data inputs; bit k drives ik.
- mem_dout  in  WORDS*DATA_W  flattened word outputs; word n occupies bits [n*DATA_W +: DATA_W].
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values (asynchronous): state IDLE, req_ready 1, rsp_valid 0, rsp_wr 0, rsp_data 0, mem_rw 1, mem_adr 0, mem_din 0, busy 0, phase counter 0.
- mem_rw is 0 only in state STROBE. It is registered and glitch-free.
- mem_adr and mem_din are registered. They change only on request acceptance.
- States and transitions:
  - IDLE: req_ready = 1. On req_valid && req_ready, latch wr/adr/data into the mem_* and rsp_wr registers, then go to SETUP.
  - SETUP: one cycle with the address stable and mem_rw = 1.
    - Write: go to STROBE and load the counter with WR_CYCLES-1.
    - Read with RD_LAT = 0: go to CAPTURE.
    - Read with RD_LAT > 0: go to WAIT and load the counter with RD_LAT-1.
  - STROBE: mem_rw = 0. Decrement the counter; at 0, go to HOLD.
  - HOLD: one cycle with mem_rw = 1 and address/data unchanged, then go to RESP with rsp_data = 0.
  - WAIT: decrement the counter; at 0, go to CAPTURE.
  - CAPTURE: register mem_dout word[mem_adr] into rsp_data, then go to RESP.
  - RESP: rsp_valid = 1, with rsp_data and rsp_wr stable. When rsp_ready is high, deassert rsp_valid and return to IDLE.
- req_ready is 0 in all states except IDLE, so there is no request overlap and at most one transaction is outstanding.
- Latency, request accept to rsp_valid rising:
  - Write: 2 + WR_CYCLES + 1 cycles (4 at defaults).
  - Read: 2 + RD_LAT + 1 cycles (4 at defaults; 3 with RD_LAT = 0).
- A response held under backpressure holds all outputs indefinitely, and mem_rw stays at 1.
- req_valid dropping after acceptance has no effect. Request inputs are ignored outside IDLE.
- Reset asserted mid-STROBE forces mem_rw to 1 immediately (asynchronously). The in-flight write's memory content is undefined, and no response is issued.
- An address of WORDS-1 followed by address 0 needs no special handling; there is no wrap logic, and the address is used as given.
- Out-of-range parameters are a compile-time error (static assertion).

Decomposition:
- Shared package `mem_pkg`:
  - state enum: IDLE, SETUP, STROBE, HOLD, WAIT, CAPTURE, RESP;
  - constants: MEM_RW_READ = 1, MEM_RW_WRITE = 0, default ADDR_W / DATA_W.
- One natural sub-module, `mem_word_sel`: a combinational WORDS:1 mux of DATA_W bits from the flattened mem_dout. It is reusable by other array consumers.
- The FSM and counter stay in `mem_ctrl`.

Test Plan:
- Write then read, defaults: write adr 5, data 0xA7, then read adr 5.
  - Required: mem_rw low exactly 1 cycle with mem_adr = 5 and mem_din = 0xA7.
  - Required: the read response gives rsp_data = 0xA7 and rsp_wr = 0, with rsp_valid 4 cycles after acceptance.
- Fill and verify all words: write word n = 0x11*n for n = 0..7, then read all eight in order.
  - Required: each read returns 0x11*n.
  - Required: no other word changes, checked via a mem_dout snapshot after each write.
- Response backpressure: hold rsp_ready = 0 for 10 cycles on a read of adr 3.
  - Required: rsp_valid and rsp_data stay stable and req_ready stays 0.
  - Required: after rsp_ready rises, rsp_valid falls next cycle and req_ready returns to 1.
- Parameter sweep: WR_CYCLES = 3, RD_LAT = 0.
  - Required: mem_rw low for exactly 3 consecutive cycles.
  - Required: write latency 6 cycles and read latency 3 cycles.
- Reset mid-write: assert rst during STROBE.
  - Required: mem_rw = 1 in the same cycle, before the next clock edge.
  - Required: state IDLE, rsp_valid = 0, and req_ready = 1 after release.
- Ignored request: toggle req_valid with different adr/data while busy.
  - Required: mem_adr and mem_din do not change until the next IDLE acceptance.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the word-memory controller and its helpers.
package mem_pkg;

  localparam int DEF_ADDR_W = 3;
  localparam int DEF_DATA_W = 8;

  localparam logic MEM_RW_READ  = 1'b1;
  localparam logic MEM_RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    HOLD    = 3'd3,
    WAIT    = 3'd4,
    CAPTURE = 3'd5,
    RESP    = 3'd6
  } state_t;

endpackage

// File: rtl/mem_word_sel.sv
// Combinational WORDS:1 word selector over a flattened word-output bus.
module mem_word_sel
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [ADDR_W-1:0]             i_sel,
  input  logic [(2**ADDR_W)*DATA_W-1:0] i_flat,
  output logic [DATA_W-1:0]             o_word
);

  assign o_word = i_flat[i_sel*DATA_W +: DATA_W];

endmodule

// File: rtl/mem_ctrl.sv
// Request/response sequencer for the gate-level word memory: setup, RW strobe,
// hold for writes; setup, wait, capture for reads.
//   state   | meaning
//   IDLE    | ready for a request
//   SETUP   | address/data stable, RW high
//   STROBE  | RW low for WR_CYCLES cycles
//   HOLD    | RW back high, address/data held
//   WAIT    | read access time, RD_LAT cycles
//   CAPTURE | register the addressed word
//   RESP    | response presented until consumed
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int WR_CYCLES = 1,
  parameter int RD_LAT    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_wr,
  input  logic [ADDR_W-1:0]             req_adr,
  input  logic [DATA_W-1:0]             req_data,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_wr,
  output logic [DATA_W-1:0]             rsp_data,
  output logic                          mem_rw,
  output logic [ADDR_W-1:0]             mem_adr,
  output logic [DATA_W-1:0]             mem_din,
  input  logic [(2**ADDR_W)*DATA_W-1:0] mem_dout,
  output logic                          busy
);

  if (WR_CYCLES < 1 || WR_CYCLES > 15) begin : g_bad_wr_cycles
    $error("mem_ctrl: WR_CYCLES must be 1..15");
  end
  if (RD_LAT < 0 || RD_LAT > 15) begin : g_bad_rd_lat
    $error("mem_ctrl: RD_LAT must be 0..15");
  end

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_rsp_valid;
  logic                r_rsp_wr;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_mem_rw;
  logic [ADDR_W-1:0]   r_mem_adr;
  logic [DATA_W-1:0]   r_mem_din;
  logic [DATA_W-1:0]   w_word;

  mem_word_sel #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_word_sel (
    .i_sel  (r_mem_adr),
    .i_flat (mem_dout),
    .o_word (w_word)
  );

  // mem_rw is a flop output so the array never sees a decode glitch on RW.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_wr    <= 1'b0;
      r_rsp_data  <= '0;
      r_mem_rw    <= MEM_RW_READ;
      r_mem_adr   <= '0;
      r_mem_din   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_rsp_wr  <= req_wr;
            r_mem_adr <= req_adr;
            r_mem_din <= req_data;
            r_state   <= SETUP;
          end
        end
        SETUP: begin
          if (r_rsp_wr) begin
            r_cnt    <= 4'(WR_CYCLES - 1);
            r_mem_rw <= MEM_RW_WRITE;
            r_state  <= STROBE;
          end else if (RD_LAT == 0) begin
            r_state <= CAPTURE;
          end else begin
            r_cnt   <= 4'(RD_LAT - 1);
            r_state <= WAIT;
          end
        end
        STROBE: begin
          if (r_cnt == 4'd0) begin
            r_mem_rw <= MEM_RW_READ;
            r_state  <= HOLD;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        HOLD: begin
          r_rsp_data  <= '0;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        WAIT: begin
          if (r_cnt == 4'd0) r_state <= CAPTURE;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        CAPTURE: begin
          r_rsp_data  <= w_word;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_wr    = r_rsp_wr;
  assign rsp_data  = r_rsp_data;
  assign mem_rw    = r_mem_rw;
  assign mem_adr   = r_mem_adr;
  assign mem_din   = r_mem_din;

endmodule
